// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// even-parity helper used by both the transmit and receive parity logic.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Even-parity bit for a data word: the bit that makes the total count of
  // ones (data plus parity) even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_sipo.sv
// Serial-in/parallel-out register for the UART receiver. Bits arrive LSB
// first, so each new bit enters at the MSB end and the word moves right;
// after DATA_BITS shifts the first bit received sits in bit 0.
module sipo
  import uart_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 shift,
  input  logic                 din,
  output logic [DATA_BITS-1:0] dout
);

  // Shift one sampled bit in; reset discards any partial word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dout <= '0;
    end else if (shift) begin
      dout <= {din, dout[DATA_BITS-1:1]};
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises the serial line, samples each bit at mid-bit,
// rebuilds the byte through the SIPO and reports parity and framing errors.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  logic [1:0]           sync_reg;
  logic                 rx_s;
  rx_state_t            state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [2:0]           idx_reg, idx_next;
  logic                 armed_reg, armed_next;
  logic                 perr_pend_reg, perr_pend_next;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 data_valid_reg, data_valid_next;
  logic                 parity_err_reg, parity_err_next;
  logic                 frame_err_reg, frame_err_next;
  logic                 shift;
  logic [DATA_BITS-1:0] sipo_dout;

  // Two-flop synchroniser; flops reset high so the line looks idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx_in};
    end
  end

  assign rx_s = sync_reg[1];

  sipo u_sipo (
    .clock (clock),
    .reset (reset),
    .shift (shift),
    .din   (rx_s),
    .dout  (sipo_dout)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      armed_reg      <= 1'b0;
      perr_pend_reg  <= 1'b0;
      data_reg       <= '0;
      data_valid_reg <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      armed_reg      <= armed_next;
      perr_pend_reg  <= perr_pend_next;
      data_reg       <= data_next;
      data_valid_reg <= data_valid_next;
      parity_err_reg <= parity_err_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  // Next-state logic: mid-bit sampling schedule for start, data, parity, stop.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg + 1'b1;
    idx_next        = idx_reg;
    armed_next      = armed_reg;
    perr_pend_next  = perr_pend_reg;
    data_next       = data_reg;
    data_valid_next = 1'b0;
    parity_err_next = parity_err_reg;
    frame_err_next  = frame_err_reg;
    shift           = 1'b0;

    unique case (state_reg)
      IDLE: begin
        cnt_next = '0;
        // Arming needs a high line first, so a line held low after a
        // framing error cannot start a new frame.
        if (rx_s) begin
          armed_next = 1'b1;
        end else if (armed_reg) begin
          state_next = START;
        end
      end
      START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            state_next = IDLE;          // short low pulse: not a real start bit
          end else begin
            state_next = DATA;
            idx_next   = '0;
          end
        end
      end
      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          shift    = 1'b1;
          cnt_next = '0;
          if (idx_reg == IDX_LAST) begin
            state_next = PARITY_EN ? PARITY : STOP;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      PARITY: begin
        if (cnt_reg == BIT_LAST) begin
          perr_pend_next = even_parity(sipo_dout) ^ rx_s;
          cnt_next       = '0;
          state_next     = STOP;
        end
      end
      STOP: begin
        if (cnt_reg == BIT_LAST) begin
          data_next       = sipo_dout;
          parity_err_next = PARITY_EN ? perr_pend_reg : 1'b0;
          frame_err_next  = ~rx_s;
          data_valid_next = 1'b1;
          armed_next      = 1'b0;
          cnt_next        = '0;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign data_out   = data_reg;
  assign data_valid = data_valid_reg;
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive side of the UART serial link: it accepts the frame the transmit datapath produces and turns it back into a parallel byte. The frame is one low start bit, 8 data bits LSB-first, an optional even-parity bit, and one high stop bit. The block synchronises the asynchronous line, samples each bit at mid-bit, reassembles the byte in a SIPO, and reports parity and framing errors. It sits between the pad-side `rx_in` line and the host-side byte consumer.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Must be even and ≥ 4.
- `PARITY_EN`, default 1: 1 means a parity bit is present (even parity); 0 means no parity bit.

Ports:
- `clock`  in  1: the block's single clock. All state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `rx_in`  in  1: serial line, asynchronous, idles high.
- `data_out`  out  8: last received byte. Held until the next frame completes.
- `data_valid`  out  1: one-cycle pulse when a frame completes.
- `parity_err`  out  1: parity mismatch for the frame. Valid with `data_valid`, held until the next frame.
- `frame_err`  out  1: stop bit sampled low. Valid with `data_valid`, held until the next frame.
- `busy`  out  1: high in every state except IDLE.

## Operation
- `rx_in` passes through a 2-flop synchroniser; the result is `rx_s`. All decisions use `rx_s`.
- The FSM has states IDLE, START, DATA, PARITY, STOP, plus a bit counter `cnt` and a bit index `idx` (0–7).
- IDLE:
  - The `armed` flag sets whenever `rx_s` = 1.
  - When `armed` and `rx_s` = 0: go to START, clear `cnt`.
  - A line stuck low after a framing error never retriggers the FSM.
- START: at `cnt` = `CLKS_PER_BIT`/2 − 1, sample `rx_s`.
  - If it is 1, treat it as a glitch: return to IDLE with no output.
  - If it is 0: go to DATA, `idx` = 0, `cnt` = 0.
- DATA: at `cnt` = `CLKS_PER_BIT` − 1, shift `rx_s` into the SIPO at bit position `idx` (LSB first), then reset `cnt`.
  - After `idx` = 7, go to PARITY, or to STOP when `PARITY_EN` = 0.
- PARITY: sample once at `cnt` = `CLKS_PER_BIT` − 1.
  - Compute err = XOR(data bits, parity bit). Even parity means the total count of ones, including the parity bit, is even; err = 1 flags a mismatch.
- STOP: sample once at `cnt` = `CLKS_PER_BIT` − 1.
  - On that edge, register `data_out`, `parity_err` (0 when `PARITY_EN` = 0), and `frame_err` = ~`rx_s`.
  - Set `data_valid` and return to IDLE with `armed` cleared.
- Reset clears everything, mid-frame included: the FSM returns to IDLE, counters clear, `armed` = 0, and the partial byte is discarded.
- Reset values: `data_out` = 8'h00; `data_valid`, `parity_err`, `frame_err`, `busy` = 0. Synchroniser flops reset to 1.
- No flow control and no overrun flag. The consumer must take `data_out` before the next `data_valid`.

## Timing
- Let E be the edge at which IDLE observes `rx_s` = 0. `rx_s` lags `rx_in` by 2 edges.
- Bit k is sampled at edge E + `CLKS_PER_BIT`/2 + k·`CLKS_PER_BIT`:
  - k = 0: start bit.
  - k = 1–8: data bits.
  - k = 9: parity bit, only when `PARITY_EN` = 1.
  - Last k: stop bit (k = 10 with parity, 9 without).
- `data_valid` is high during the single cycle after the stop-sample edge.
- `busy` rises the cycle after E and falls with the stop-sample edge.
- Back-to-back frames: the next start edge may arrive any time after stop mid-bit. IDLE re-arms on the first `rx_s` = 1 cycle.
- Tolerance: a total baud mismatch of ±(`CLKS_PER_BIT`/2 − 1) cycles over the frame is absorbed.

## Structure
- Package `uart_pkg`:
  - state enum `rx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - constant `DATA_BITS` = 8;
  - an even-parity helper function shared with the transmit parity logic.
- Sub-module `sipo`: the serial-in/parallel-out shift register, the mirror of the transmit PISO. Ports: `clock`, `reset`, `shift`, `din`, `dout[7:0]`.
- FSM, counters and synchroniser live in `uart_rx`.

## Test plan
- Reset then idle line: with `rx_in` = 1 for 1000 cycles, all outputs stay 0 and `data_valid` never pulses.
- Good frame, `CLKS_PER_BIT` = 16: send 0xA5 with parity 0.
  - `data_out` = 8'hA5, `parity_err` = 0, `frame_err` = 0.
  - A single `data_valid` pulse at E + 169.
- Parity error: send 0x01 with parity bit 0 → `data_out` = 8'h01, `parity_err` = 1.
- Framing error plus stuck line: send 0x3C with the stop bit low, then hold `rx_in` low.
  - `frame_err` = 1 and exactly one `data_valid` pulse; no second frame until the line returns high.
- Glitch rejection: a 4-cycle low pulse on `rx_in` → FSM returns to IDLE, no `data_valid`, `busy` high only for 8 cycles.
- Reset mid-frame, then recovery:
  - Assert `reset` during data bit 3 → outputs are 0 immediately.
  - Then send 0x5A back-to-back with 0xFF → both bytes are received with no errors.
